hdlc_protocol_checker: RTL and testbench
========================================

// Module: hdlc_protocol_checker
// PURPOSE
// - Synthesisable, parametrised checker for the HDLC link: same three rules as the bench-only
//   checks (flag detect, Rx abort signalling, Tx abort flag), now as RTL with counters.
// - Sits beside the HDLC core and snoops Rx/Tx and status strobes; never drives the core.
// - Adds programmable latencies, sticky per-rule error bits, a saturating error counter and clear.
// PARAMETERS
// - FLAG_LAT      2   cycles from last flag bit sampled on Rx to required Rx_FlagDetect (1..15)
// - ABORT_ONES    7   number of Tx=1 cycles required after the leading Tx=0 of an abort flag (2..15)
// - CNT_W         16  width of ErrCnt (and PassCnt)
// PORTS
// - Clk             in   1      system clock, all logic on rising edge
// - Rst             in   1      reset, asynchronous, active-high
// - Clr             in   1      sync clear of ErrCnt, ErrVec, PassCnt
// - Rx              in   1      serial receive line
// - Tx              in   1      serial transmit line
// - Rx_FlagDetect   in   1      core flag-detect strobe
// - Rx_ValidFrame   in   1      core in-frame indicator
// - Rx_AbortDetect  in   1      core abort-detect strobe
// - Rx_AbortSignal  in   1      core abort-signal output
// - Tx_AbortFrame   in   1      core Tx abort request
// - ErrVec          out  3      sticky: [0] flag, [1] Rx abort, [2] Tx abort flag
// - ErrCnt          out  CNT_W  total failures, saturating at all-ones
// - ErrPulse        out  1      registered, high 1 cycle after any rule failure
// BEHAVIOUR
// - Reset: ErrVec=0, ErrCnt=0, ErrPulse=0, PassCnt=0, shift regs=0, FSM=IDLE. Reset mid-check aborts it.
// - Rule 0 (flag): 8-bit Rx history in arrival order; match 0,1,1,1,1,1,1,0 at cycle t
//   (t = cycle last 0 sampled) pushes a 1 into a FLAG_LAT-deep delay line; at t+FLAG_LAT
//   Rx_FlagDetect must be 1, else fail. Back-to-back flags sharing a 0 (7 cycles apart) are
//   checked independently. History initialised to 8'hFF after reset, so no match before 8 bits seen.
// - Rule 1 (Rx abort): Rx_AbortDetect && Rx_ValidFrame at t -> Rx_AbortSignal=1 at t+1, else fail.
// - Rule 2 (Tx abort) FSM, states IDLE, ZERO, ONES:
//   - IDLE: rising edge of Tx_AbortFrame (0 at t-1, 1 at t) -> ZERO.
//   - ZERO: Tx must be 0 (cycle t+1); ok -> ONES, cnt=0; else fail -> IDLE.
//   - ONES: Tx must be 1; cnt==ABORT_ONES-1 -> pass, IDLE; Tx=0 -> fail, IDLE.
//   - Rising edges of Tx_AbortFrame while not IDLE are ignored (no restart).
// - Failure of rule k sets ErrVec[k]; ErrPulse=1 next cycle. Up to 3 rules may fail in one cycle;
//   ErrCnt adds the count (0..3) and clamps at 2^CNT_W-1 (no wrap).
// - Clr=1: ErrVec, ErrCnt, PassCnt cleared; failures in that same cycle are dropped (Clr wins).
//   Clr does not reset the FSM or delay lines (checks in flight continue).
// - ErrCnt/ErrVec/ErrPulse update one cycle after the failing sample cycle.
// CONFIGURATION
// - HDLC_CHK_PASSCNT_EN defined: extra port PassCnt out CNT_W, counts successful rule checks
//   (flag matched with detect, abort signalled, abort flag complete), sum per cycle, saturating,
//   cleared by Rst/Clr. Undefined: port and logic absent; all other behaviour identical.
// TESTING
// - Rx drives 0,1,1,1,1,1,1,0; core raises Rx_FlagDetect 2 cycles after last 0 -> ErrVec=0, ErrCnt=0.
// - Same flag, Rx_FlagDetect held 0 -> ErrVec=3'b001, ErrCnt=1, ErrPulse 1-cycle pulse.
// - Rx_AbortDetect=1, Rx_ValidFrame=1, next cycle Rx_AbortSignal=0 -> ErrVec[1]=1, ErrCnt=1;
//   with Rx_ValidFrame=0 -> no error.
// - Tx_AbortFrame 0->1, Tx = 0 then 1 x7 -> no error (PassCnt=1 if enabled); Tx = 0,1,1,1,0 -> ErrVec[2]=1.
// - CNT_W=2, force 5 flag failures -> ErrCnt=3 (saturated); assert Clr -> ErrCnt=0, ErrVec=0.
// - Rst asserted mid-ONES, released, Tx=0 -> no Tx abort error; all outputs 0.

Source files
------------

// File: rtl/hdlc_protocol_checker.sv
// hdlc_protocol_checker: snooping HDLC rule checker (flag detect, Rx abort, Tx abort flag) with sticky errors and counters.
// Define HDLC_CHK_PASSCNT_EN to add the o_pass_cnt successful-check counter.
module hdlc_protocol_checker #(
    parameter int FLAG_LAT   = 2,
    parameter int ABORT_ONES = 7,
    parameter int CNT_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_rx,
    input  logic             i_tx,
    input  logic             i_rx_flag_detect,
    input  logic             i_rx_valid_frame,
    input  logic             i_rx_abort_detect,
    input  logic             i_rx_abort_signal,
    input  logic             i_tx_abort_frame,
    output logic [2:0]       o_err_vec,
    output logic [CNT_W-1:0] o_err_cnt,
`ifdef HDLC_CHK_PASSCNT_EN
    output logic             o_err_pulse,
    output logic [CNT_W-1:0] o_pass_cnt
`else
    output logic             o_err_pulse
`endif
);
    typedef enum logic [1:0] {IDLE, ZERO, ONES} state_t;
    state_t              r_state, w_state_nxt;
    logic [7:0]          r_rx_hist;
    logic [FLAG_LAT-1:0] r_flag_dl;
    logic                r_abort_pend;
    logic                r_af_d;
    logic [3:0]          r_ones_cnt, w_ones_cnt_nxt;
    logic                w_flag_match;
    logic                w_tx_fail;
    logic [2:0]          w_fail;
    logic [1:0]          w_nfail;
    logic [2:0]          r_err_vec;
    logic [CNT_W-1:0]    r_err_cnt;
    logic                r_err_pulse;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
        logic [CNT_W+1:0] s;
        s = {2'b00, a} + {{CNT_W{1'b0}}, b};
        return (s[CNT_W+1:CNT_W] != 2'b00) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    // match includes the bit being sampled now, so t is the cycle of the closing 0
    assign w_flag_match = {r_rx_hist[6:0], i_rx} == 8'h7E;
    assign w_fail  = {w_tx_fail,
                      r_abort_pend & ~i_rx_abort_signal,
                      r_flag_dl[FLAG_LAT-1] & ~i_rx_flag_detect};
    assign w_nfail = 2'(w_fail[0]) + 2'(w_fail[1]) + 2'(w_fail[2]);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rx_hist    <= 8'hFF;
            r_flag_dl    <= '0;
            r_abort_pend <= 1'b0;
            r_af_d       <= 1'b0;
            r_state      <= IDLE;
            r_ones_cnt   <= '0;
        end else begin
            r_rx_hist    <= {r_rx_hist[6:0], i_rx};
            r_flag_dl    <= FLAG_LAT'({r_flag_dl, w_flag_match});
            r_abort_pend <= i_rx_abort_detect & i_rx_valid_frame;
            r_af_d       <= i_tx_abort_frame;
            r_state      <= w_state_nxt;
            r_ones_cnt   <= w_ones_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ones_cnt_nxt = r_ones_cnt;
        w_tx_fail      = 1'b0;
        case (r_state)
            IDLE: w_state_nxt = (i_tx_abort_frame && !r_af_d) ? ZERO : IDLE;
            ZERO: begin
                w_state_nxt    = i_tx ? IDLE : ONES;
                w_ones_cnt_nxt = '0;
                w_tx_fail      = i_tx;
            end
            ONES: begin
                w_ones_cnt_nxt = r_ones_cnt + 4'd1;
                w_tx_fail      = ~i_tx;
                w_state_nxt    = (!i_tx || r_ones_cnt == 4'(ABORT_ONES - 1)) ? IDLE : ONES;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // a clear in the same cycle as a failure discards that failure entirely
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err_vec   <= '0;
            r_err_cnt   <= '0;
            r_err_pulse <= 1'b0;
        end else begin
            r_err_vec   <= i_clr ? 3'b000 : (r_err_vec | w_fail);
            r_err_cnt   <= i_clr ? '0 : sat_add(r_err_cnt, w_nfail);
            r_err_pulse <= (|w_fail) & ~i_clr;
        end
    end

    assign o_err_vec   = r_err_vec;
    assign o_err_cnt   = r_err_cnt;
    assign o_err_pulse = r_err_pulse;

`ifdef HDLC_CHK_PASSCNT_EN
    logic [2:0]       w_pass;
    logic [1:0]       w_npass;
    logic [CNT_W-1:0] r_pass_cnt;

    assign w_pass  = {r_state == ONES && i_tx && r_ones_cnt == 4'(ABORT_ONES - 1),
                      r_abort_pend & i_rx_abort_signal,
                      r_flag_dl[FLAG_LAT-1] & i_rx_flag_detect};
    assign w_npass = 2'(w_pass[0]) + 2'(w_pass[1]) + 2'(w_pass[2]);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_pass_cnt <= '0;
        else       r_pass_cnt <= i_clr ? '0 : sat_add(r_pass_cnt, w_npass);
    end

    assign o_pass_cnt = r_pass_cnt;
`endif
endmodule

// File: tb/tb_hdlc_protocol_checker.sv
// tb_hdlc_protocol_checker: vector table, directed Tx-abort/reset/saturation sequences and random stimulus
// against a queue-based reference model; a CNT_W=2 twin shares all inputs to exercise saturation.
module tb_hdlc_protocol_checker;
    localparam int FL = 2;
    localparam int AO = 7;

    logic clk = 1'b0, rst = 1'b1, clr = 1'b0, rx = 1'b1, tx = 1'b1;
    logic fd = 1'b0, vf = 1'b0, ad = 1'b0, asig = 1'b0, af = 1'b0;
    logic [2:0]  err_vec, sat_vec;
    logic [15:0] err_cnt;
    logic [1:0]  sat_cnt;
    logic        err_pulse, sat_pulse;
`ifdef HDLC_CHK_PASSCNT_EN
    logic [15:0] pass_cnt;
    logic [1:0]  sat_pass;
`endif

    always #5 clk = ~clk;

    hdlc_protocol_checker #(.FLAG_LAT(FL), .ABORT_ONES(AO), .CNT_W(16)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_rx(rx), .i_tx(tx),
        .i_rx_flag_detect(fd), .i_rx_valid_frame(vf), .i_rx_abort_detect(ad),
        .i_rx_abort_signal(asig), .i_tx_abort_frame(af),
        .o_err_vec(err_vec), .o_err_cnt(err_cnt),
`ifdef HDLC_CHK_PASSCNT_EN
        .o_pass_cnt(pass_cnt),
`endif
        .o_err_pulse(err_pulse));

    hdlc_protocol_checker #(.FLAG_LAT(FL), .ABORT_ONES(AO), .CNT_W(2)) u_sat (
        .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_rx(rx), .i_tx(tx),
        .i_rx_flag_detect(fd), .i_rx_valid_frame(vf), .i_rx_abort_detect(ad),
        .i_rx_abort_signal(asig), .i_tx_abort_frame(af),
        .o_err_vec(sat_vec), .o_err_cnt(sat_cnt),
`ifdef HDLC_CHK_PASSCNT_EN
        .o_pass_cnt(sat_pass),
`endif
        .o_err_pulse(sat_pulse));

    int n_chk = 0, n_pass = 0;

    // reference model state
    int       rxq[$];
    int       due[$];
    int       pat[8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    bit       p_advf, p_af;
    int       tx_start, cyc;
    longint   m_cnt;
    bit [2:0] m_vec;
    bit       m_pulse;
`ifdef HDLC_CHK_PASSCNT_EN
    longint   m_pass;
`endif

    typedef struct {
        bit rx, fd, ad, vf, asig, clr;
        bit [2:0] vec;
        int cnt;
        bit pulse;
    } vec_t;
    vec_t tbl[$];

    function automatic longint lmin(longint a, longint b);
        return a < b ? a : b;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (model cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        rxq.delete();
        due.delete();
        p_advf = 0; p_af = 0; tx_start = -1; cyc = 0;
        m_cnt = 0; m_vec = 0; m_pulse = 0;
`ifdef HDLC_CHK_PASSCNT_EN
        m_pass = 0;
`endif
    endtask

    task automatic model_eval();
        bit [2:0] chk, ok, f;
        bit match;
        int k;
        chk = 0; ok = 0;
        if (due.size() > 0 && due[0] == cyc) begin
            void'(due.pop_front());
            chk[0] = 1; ok[0] = fd;
        end
        rxq.push_back(int'(rx));
        if (rxq.size() > 8) void'(rxq.pop_front());
        match = rxq.size() == 8;
        for (int i = 0; i < 8; i++) if (rxq.size() == 8 && rxq[i] != pat[i]) match = 0;
        if (match) due.push_back(cyc + FL);
        if (p_advf) begin chk[1] = 1; ok[1] = asig; end
        p_advf = ad && vf;
        if (tx_start >= 0) begin
            k = cyc - tx_start - 1;
            ok[2] = (int'(tx) == ((k == 0) ? 0 : 1));
            chk[2] = !ok[2] || k == AO;
            if (chk[2]) tx_start = -1;
        end else if (af && !p_af) tx_start = cyc;
        p_af = af;
        f = chk & ~ok;
        m_pulse = (f != 0) && !clr;
        if (clr) begin
            m_vec = 0; m_cnt = 0;
`ifdef HDLC_CHK_PASSCNT_EN
            m_pass = 0;
`endif
        end else begin
            m_vec |= f;
            m_cnt += f[0] + f[1] + f[2];
`ifdef HDLC_CHK_PASSCNT_EN
            m_pass += (chk[0] & ok[0]) + (chk[1] & ok[1]) + (chk[2] & ok[2]);
`endif
        end
        cyc++;
    endtask

    task automatic check_model();
        check("err_vec", 64'(err_vec), 64'(m_vec));
        check("err_cnt", 64'(err_cnt), 64'(lmin(m_cnt, 65535)));
        check("err_pulse", 64'(err_pulse), 64'(m_pulse));
        check("sat_vec", 64'(sat_vec), 64'(m_vec));
        check("sat_cnt", 64'(sat_cnt), 64'(lmin(m_cnt, 3)));
        check("sat_pulse", 64'(sat_pulse), 64'(m_pulse));
`ifdef HDLC_CHK_PASSCNT_EN
        check("pass_cnt", 64'(pass_cnt), 64'(lmin(m_pass, 65535)));
        check("sat_pass", 64'(sat_pass), 64'(lmin(m_pass, 3)));
`endif
    endtask

    task automatic drive(bit r, bit f, bit a, bit v, bit s, bit afr, bit t, bit c);
        rx = r; fd = f; ad = a; vf = v; asig = s; af = afr; tx = t; clr = c;
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic txc(bit afr, bit t);
        drive(1, 0, 0, 0, 0, afr, t, 0);
        tick();
    endtask

    task automatic do_reset();
        rst = 1;
        model_reset();
        #2;
        check_model();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic add(bit r, bit f, bit a, bit v, bit s, bit c, bit [2:0] ev, int ec, bit ep);
        vec_t t;
        t.rx = r; t.fd = f; t.ad = a; t.vf = v; t.asig = s; t.clr = c;
        t.vec = ev; t.cnt = ec; t.pulse = ep;
        tbl.push_back(t);
    endtask

    int rxsrc[$];
    int kk;
    bit ex;

    initial begin
        // flag with detect two cycles after the closing 0: no error
        add(0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        repeat (6) add(1, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        add(0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        add(1, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        add(1, 1, 0, 0, 0, 0, 3'b000, 0, 0);
        // flag with detect held low: rule 0 fails
        add(0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        repeat (6) add(1, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        add(0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        add(1, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        add(1, 0, 0, 0, 0, 0, 3'b001, 1, 1);
        add(1, 0, 0, 0, 0, 0, 3'b001, 1, 0);
        // Rx abort: missing signal fails, out-of-frame ignored, signalled passes
        add(1, 0, 1, 1, 0, 0, 3'b001, 1, 0);
        add(1, 0, 0, 0, 0, 0, 3'b011, 2, 1);
        add(1, 0, 1, 0, 0, 0, 3'b011, 2, 0);
        add(1, 0, 0, 0, 0, 0, 3'b011, 2, 0);
        add(1, 0, 1, 1, 0, 0, 3'b011, 2, 0);
        add(1, 0, 0, 0, 1, 0, 3'b011, 2, 0);
        add(1, 0, 0, 0, 0, 1, 3'b000, 0, 0);

        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        check_model();
        check("reset_vec", 64'(err_vec), 64'd0);
        check("reset_cnt", 64'(err_cnt), 64'd0);
        check("reset_pulse", 64'(err_pulse), 64'd0);

        drive(1, 0, 0, 0, 0, 0, 1, 1);
        tick();
        foreach (tbl[i]) begin
            drive(tbl[i].rx, tbl[i].fd, tbl[i].ad, tbl[i].vf, tbl[i].asig, 0, 1, tbl[i].clr);
            tick();
            check($sformatf("tbl%0d_vec", i), 64'(err_vec), 64'(tbl[i].vec));
            check($sformatf("tbl%0d_cnt", i), 64'(err_cnt), 64'(tbl[i].cnt));
            check($sformatf("tbl%0d_pulse", i), 64'(err_pulse), 64'(tbl[i].pulse));
        end

        // complete abort flag: 0 then seven 1s
        txc(1, 1); txc(1, 0);
        repeat (AO) txc(1, 1);
        check("txok_vec", 64'(err_vec), 64'd0);
        check("txok_cnt", 64'(err_cnt), 64'd0);
`ifdef HDLC_CHK_PASSCNT_EN
        check("txok_pass", 64'(pass_cnt), 64'd1);
`endif
        txc(0, 1);
        // broken abort flag: 0,1,1,1,0
        txc(1, 1); txc(1, 0); txc(1, 1); txc(1, 1); txc(1, 1); txc(1, 0);
        check("txbad_vec", 64'(err_vec), 64'd4);
        check("txbad_cnt", 64'(err_cnt), 64'd1);
        check("txbad_pulse", 64'(err_pulse), 64'd1);
        txc(0, 1);
        // rising edge while checking is ignored
        txc(1, 1); txc(1, 0); txc(0, 1); txc(1, 1);
        repeat (AO - 2) txc(1, 1);
        txc(1, 1);
        check("txign_vec", 64'(err_vec), 64'd4);
        check("txign_cnt", 64'(err_cnt), 64'd1);
        check("txign_pulse", 64'(err_pulse), 64'd0);
        // reset in the middle of the ones run
        txc(0, 1); txc(1, 1); txc(1, 0); txc(1, 1); txc(1, 1);
        drive(1, 0, 0, 0, 0, 0, 1, 0);
        do_reset();
        repeat (3) txc(0, 0);
        check("rstmid_vec", 64'(err_vec), 64'd0);
        check("rstmid_cnt", 64'(err_cnt), 64'd0);
        check("rstmid_pulse", 64'(err_pulse), 64'd0);

        // five back-to-back failing flags sharing their 0s
        drive(0, 0, 0, 0, 0, 0, 1, 0); tick();
        repeat (5) begin
            repeat (6) begin drive(1, 0, 0, 0, 0, 0, 1, 0); tick(); end
            drive(0, 0, 0, 0, 0, 0, 1, 0); tick();
        end
        repeat (FL) begin drive(1, 0, 0, 0, 0, 0, 1, 0); tick(); end
        check("sat_cnt3", 64'(sat_cnt), 64'd3);
        check("sat_big5", 64'(err_cnt), 64'd5);
        check("sat_vec1", 64'(sat_vec), 64'd1);
        drive(1, 0, 0, 0, 0, 0, 1, 1); tick();
        check("clr_cnt", 64'(sat_cnt), 64'd0);
        check("clr_big", 64'(err_cnt), 64'd0);
        check("clr_vec", 64'(err_vec), 64'd0);

        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset();
            if (rxsrc.size() == 0) begin
                if ($urandom_range(0, 3) == 0) foreach (pat[j]) rxsrc.push_back(pat[j]);
                else rxsrc.push_back(int'($urandom_range(0, 1)));
            end
            rx   = rxsrc.pop_front() != 0;
            fd   = $urandom_range(0, 1) == 1;
            ad   = $urandom_range(0, 3) == 0;
            vf   = $urandom_range(0, 1) == 1;
            asig = $urandom_range(0, 1) == 1;
            af   = ($urandom_range(0, 5) == 0) ? ~af : af;
            clr  = $urandom_range(0, 79) == 0;
            if (tx_start >= 0) begin
                kk = cyc - tx_start - 1;
                ex = kk != 0;
                tx = ($urandom_range(0, 9) == 0) ? ~ex : ex;
            end else tx = $urandom_range(0, 1) == 1;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
